// File: rtl/seq_mac_arbiter_if.sv
// Requester, response and MAC-side signals of seq_mac_arbiter; master = requesters + MAC, slave = arbiter.
// Pure wiring: no latency, flow control is the valid/ready pairs carried here.
interface seq_mac_arbiter_if #(
  parameter int R         = 4,
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int MAX_WIDTH = 16,
  parameter int P         = 2
);
  localparam int BSW = $clog2(MAX_WIDTH / P) + 1;

  logic [R-1:0]                                req_valid_i;
  logic [R-1:0]                                req_ready_o;
  logic [R-1:0][M-1:0][K-1:0][MAX_WIDTH-1:0]   req_a_i;
  logic [R-1:0][K-1:0][N-1:0][MAX_WIDTH-1:0]   req_b_i;
  logic [R-1:0][M-1:0][N-1:0][31:0]            req_c_i;
  logic [R-1:0][BSW-1:0]                       req_bitsize_i;

  logic [R-1:0]                                rsp_valid_o;
  logic [R-1:0]                                rsp_ready_i;
  logic [M-1:0][N-1:0][31:0]                   rsp_d_o;
  logic                                        rsp_err_o;

  logic [M-1:0][K-1:0][MAX_WIDTH-1:0]          mac_a_o;
  logic [K-1:0][N-1:0][MAX_WIDTH-1:0]          mac_b_o;
  logic [M-1:0][N-1:0][31:0]                   mac_c_o;
  logic [BSW-1:0]                              mac_bitsize_o;
  logic                                        mac_valid_o;
  logic                                        mac_ready_i;
  logic                                        mac_valid_i;
  logic                                        mac_ready_o;
  logic [M-1:0][N-1:0][31:0]                   mac_d_i;

  modport master (
    output req_valid_i, req_a_i, req_b_i, req_c_i, req_bitsize_i, rsp_ready_i,
    output mac_ready_i, mac_valid_i, mac_d_i,
    input  req_ready_o, rsp_valid_o, rsp_d_o, rsp_err_o,
    input  mac_a_o, mac_b_o, mac_c_o, mac_bitsize_o, mac_valid_o, mac_ready_o
  );

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_c_i, req_bitsize_i, rsp_ready_i,
    input  mac_ready_i, mac_valid_i, mac_d_i,
    output req_ready_o, rsp_valid_o, rsp_d_o, rsp_err_o,
    output mac_a_o, mac_b_o, mac_c_o, mac_bitsize_o, mac_valid_o, mac_ready_o
  );
endinterface

// File: rtl/seq_mac_arbiter.sv
// Round-robin sharing of one seq_MAC among R requesters; grant is combinational in IDLE, mac_valid one cycle later.
// One job in flight: req_ready is zero while busy, the response (data or error) is held until its owner accepts.
module seq_mac_arbiter #(
  parameter int R         = 4,
  parameter int M         = 2,
  parameter int N         = 2,
  parameter int K         = 2,
  parameter int MAX_WIDTH = 16,
  parameter int P         = 2,
  localparam int BSW      = $clog2(MAX_WIDTH / P) + 1,
  localparam int IDW      = $clog2(R)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  seq_mac_arbiter_if.slave   bus,
  output logic               busy_o,
  output logic [IDW-1:0]     owner_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, RUN, RESP, ERR} state_t;

  state_t                             state_q, state_d;
  logic [IDW-1:0]                     ptr_q, owner_q;
  logic [M-1:0][K-1:0][MAX_WIDTH-1:0] a_q;
  logic [K-1:0][N-1:0][MAX_WIDTH-1:0] b_q;
  logic [M-1:0][N-1:0][31:0]          c_q;
  logic [M-1:0][N-1:0][31:0]          d_q;
  logic [BSW-1:0]                     bs_q;

  logic                               gnt_vld;
  logic [IDW-1:0]                     gnt_idx;
  logic [IDW-1:0]                     scan_idx;
  logic [BSW-1:0]                     gnt_bs;
  logic                               bs_legal;
  logic                               accept;

  // Scan downward in offset so the requester closest to the pointer wins.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int i = R - 1; i >= 0; i--) begin
      scan_idx = IDW'((int'(ptr_q) + i) % R);
      if (bus.req_valid_i[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign gnt_bs   = bus.req_bitsize_i[gnt_idx];
  assign bs_legal = (gnt_bs != '0) && (gnt_bs <= BSW'(MAX_WIDTH / P));
  assign accept   = (state_q == IDLE) && gnt_vld;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (gnt_vld) state_d = bs_legal ? ISSUE : ERR;
      ISSUE:     if (bus.mac_ready_i) state_d = RUN;
      RUN:       if (bus.mac_valid_i) state_d = RESP;
      RESP, ERR: if (bus.rsp_ready_i[owner_q]) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    // Gated by reset so a combinational grant never shows while the block is held in reset.
    if (accept && rst_ni) bus.req_ready_o[gnt_idx] = 1'b1;
    if (state_q == RESP || state_q == ERR) bus.rsp_valid_o[owner_q] = 1'b1;
  end

  assign bus.rsp_err_o     = (state_q == ERR);
  assign bus.rsp_d_o       = (state_q == RESP) ? d_q : '0;
  assign bus.mac_valid_o   = (state_q == ISSUE);
  assign bus.mac_ready_o   = (state_q == RUN);
  assign bus.mac_a_o       = a_q;
  assign bus.mac_b_o       = b_q;
  assign bus.mac_c_o       = c_q;
  assign bus.mac_bitsize_o = bs_q;
  assign busy_o            = (state_q != IDLE);
  assign owner_o           = owner_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      bs_q    <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q <= gnt_idx;
        ptr_q   <= (gnt_idx == IDW'(R - 1)) ? '0 : gnt_idx + 1'b1;
        // Illegal jobs never touch the MAC operands; the MAC keeps seeing the last legal job.
        if (bs_legal) begin
          a_q  <= bus.req_a_i[gnt_idx];
          b_q  <= bus.req_b_i[gnt_idx];
          c_q  <= bus.req_c_i[gnt_idx];
          bs_q <= gnt_bs;
        end
      end
      if (state_q == RUN && bus.mac_valid_i) d_q <= bus.mac_d_i;
    end
  end

endmodule

// File: tb/tb_seq_mac_arbiter.sv
// Bench for seq_mac_arbiter: behavioural MAC plus requester/response engine with an expected-response queue.
module tb_seq_mac_arbiter;
  localparam int R   = 4;
  localparam int M   = 2;
  localparam int N   = 2;
  localparam int K   = 2;
  localparam int W   = 16;
  localparam int P   = 2;
  localparam int BSW = $clog2(W / P) + 1;
  localparam int IDW = $clog2(R);
  localparam int OPW = M*K*W + K*N*W + M*N*32 + BSW;

  typedef logic [M-1:0][K-1:0][W-1:0] a_t;
  typedef logic [K-1:0][N-1:0][W-1:0] b_t;
  typedef logic [M-1:0][N-1:0][31:0]  d_t;
  typedef struct packed { a_t a; b_t b; d_t c; logic [BSW-1:0] bs; } job_t;
  typedef struct packed { logic [IDW-1:0] own; logic err; d_t d; } exp_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           busy;
  logic [IDW-1:0] owner;

  always #5 clk = ~clk;

  seq_mac_arbiter_if #(.R(R), .M(M), .N(N), .K(K), .MAX_WIDTH(W), .P(P)) bus ();

  seq_mac_arbiter #(.R(R), .M(M), .N(N), .K(K), .MAX_WIDTH(W), .P(P)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .bus     (bus),
    .busy_o  (busy),
    .owner_o (owner)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  job_t cur [R];
  int   pend [R];
  exp_t exp_q [$];
  int   grant_q [$];

  bit   acc_flag, iss_flag, res_flag, prev_mv, stall_snap_vld, hold_snap_vld;
  int   acc_idx, mst, cnt, mac_lat, stall, hold;
  int   acc_cyc, mv_cyc, mv_cnt, iss_cnt, err_cnt, last_rsp_cyc, acc_gap;
  logic [OPW-1:0] cap, stall_snap;
  d_t   md, hold_d, last_d;
  logic [R-1:0] hold_v, last_rdy;
  logic last_err;
  int   last_own;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [OPW-1:0] ops();
    return {bus.mac_a_o, bus.mac_b_o, bus.mac_c_o, bus.mac_bitsize_o};
  endfunction

  function automatic int idx_of(input logic [R-1:0] v);
    for (int i = 0; i < R; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic d_t mac_gold(input a_t a, input b_t b, input d_t c);
    d_t d;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        int s;
        s = int'($signed(c[i][j]));
        for (int k = 0; k < K; k++)
          s = s + int'($signed(a[i][k])) * int'($signed(b[k][j]));
        d[i][j] = s;
      end
    return d;
  endfunction

  function automatic exp_t gold(input int r, input job_t j);
    exp_t e;
    e.own = IDW'(r);
    e.err = !(int'(j.bs) >= 1 && int'(j.bs) <= W / P);
    e.d   = e.err ? '0 : mac_gold(j.a, j.b, j.c);
    return e;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    for (int i = 0; i < M; i++)
      for (int k = 0; k < K; k++) j.a[i][k] = W'(int'($urandom_range(0, 30)) - 15);
    for (int k = 0; k < K; k++)
      for (int n = 0; n < N; n++) j.b[k][n] = W'(int'($urandom_range(0, 30)) - 15);
    for (int i = 0; i < M; i++)
      for (int n = 0; n < N; n++) j.c[i][n] = 32'(int'($urandom_range(0, 2000)) - 1000);
    j.bs = BSW'($urandom_range(5, W / P));
    return j;
  endfunction

  function automatic bit idle();
    for (int r = 0; r < R; r++) if (pend[r] != 0) return 1'b0;
    return exp_q.size() == 0 && !busy && !acc_flag && mst == 0;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #3;
      done = idle();
    end
    chk(tag, done, 1);
  endtask

  // Engine: +1 after the edge apply last edge's handshakes and drive; +2 sample and decide the next edge.
  initial begin : engine
    forever begin
      @(posedge clk); #1;
      if (acc_flag) begin
        acc_flag = 1'b0;
        exp_q.push_back(gold(acc_idx, cur[acc_idx]));
        grant_q.push_back(acc_idx);
        pend[acc_idx]--;
        if (pend[acc_idx] > 0) cur[acc_idx] = rand_job();
      end
      if (iss_flag) begin iss_flag = 1'b0; mst = 1; cnt = mac_lat; end
      if (res_flag) begin res_flag = 1'b0; bus.mac_valid_i = 1'b0; mst = 0; end
      for (int r = 0; r < R; r++) begin
        bus.req_valid_i[r]   = (pend[r] > 0);
        bus.req_a_i[r]       = cur[r].a;
        bus.req_b_i[r]       = cur[r].b;
        bus.req_c_i[r]       = cur[r].c;
        bus.req_bitsize_i[r] = cur[r].bs;
      end
      #1;
      cyc++;
      if (bus.req_ready_o != '0) begin
        chk("req_rdy_onehot", $countones(bus.req_ready_o), 1);
        acc_flag = 1'b1;
        acc_idx  = idx_of(bus.req_ready_o);
        last_rdy = bus.req_ready_o;
        acc_cyc  = cyc;
        acc_gap  = cyc - last_rsp_cyc;
      end
      if (bus.mac_valid_o) begin
        mv_cnt++;
        if (!prev_mv) mv_cyc = cyc;
      end
      prev_mv = bus.mac_valid_o;
      case (mst)
        0: begin
          bus.mac_ready_i = 1'b0;
          if (bus.mac_valid_o) begin
            if (stall_snap_vld) chk("issue_ops_stable", ops(), stall_snap);
            if (stall > 0) begin
              if (!stall_snap_vld) begin stall_snap = ops(); stall_snap_vld = 1'b1; end
              stall--;
            end else begin
              bus.mac_ready_i = 1'b1;
              iss_flag = 1'b1;
              iss_cnt++;
              stall_snap_vld = 1'b0;
              cap = ops();
              md  = mac_gold(bus.mac_a_o, bus.mac_b_o, bus.mac_c_o);
              chk("mac_bs_legal", (bus.mac_bitsize_o != 0 && int'(bus.mac_bitsize_o) <= W / P), 1);
            end
          end
        end
        1: begin
          bus.mac_ready_i = 1'b0;
          chk("run_ops", ops(), cap);
          if (cnt == 0) begin bus.mac_valid_i = 1'b1; bus.mac_d_i = md; mst = 2; end
          else cnt--;
        end
        default: chk("run_ops", ops(), cap);
      endcase
      if (mst == 2 && bus.mac_valid_i && bus.mac_ready_o) res_flag = 1'b1;
      if (bus.rsp_valid_o != '0) begin
        if (hold > 0) begin
          if (hold_snap_vld) begin
            chk("hold_d", bus.rsp_d_o, hold_d);
            chk("hold_v", bus.rsp_valid_o, hold_v);
          end else begin
            hold_d = bus.rsp_d_o; hold_v = bus.rsp_valid_o; hold_snap_vld = 1'b1;
          end
          chk("hold_req_rdy", bus.req_ready_o, 0);
          chk("hold_ops", ops(), cap);
          hold--;
          bus.rsp_ready_i = ~bus.rsp_valid_o;
        end else begin
          bus.rsp_ready_i = bus.rsp_valid_o;
          hold_snap_vld = 1'b0;
          last_rsp_cyc = cyc;
          last_d   = bus.rsp_d_o;
          last_err = bus.rsp_err_o;
          last_own = idx_of(bus.rsp_valid_o);
          if (bus.rsp_err_o) err_cnt++;
          if (exp_q.size() == 0) chk("unexpected_rsp", bus.rsp_valid_o, 0);
          else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_owner", last_own, e.own);
            chk("owner_o", owner, e.own);
            chk("rsp_err", bus.rsp_err_o, e.err);
            chk("rsp_d", bus.rsp_d_o, e.d);
            if (e.err) chk("err_ops_kept", ops(), cap);
          end
        end
      end else begin
        bus.rsp_ready_i = '0;
      end
    end
  end

  task automatic chk_order(input string tag, input int first, input int n);
    chk({tag, "_cnt"}, grant_q.size(), n);
    for (int i = 0; i < n && i < grant_q.size(); i++) chk(tag, grant_q[i], (first + i) % R);
  endtask

  initial begin : main
    job_t j;
    bus.req_valid_i = '0; bus.req_a_i = '0; bus.req_b_i = '0; bus.req_c_i = '0;
    bus.req_bitsize_i = '0; bus.rsp_ready_i = '0;
    bus.mac_ready_i = 1'b0; bus.mac_valid_i = 1'b0; bus.mac_d_i = '0;
    mst = 0; cnt = 0; mac_lat = 3; stall = 0; hold = 0; cap = '0;
    mv_cnt = 0; iss_cnt = 0; err_cnt = 0; last_rsp_cyc = 0;
    for (int r = 0; r < R; r++) begin cur[r] = rand_job(); pend[r] = 1; end

    // Reset with every requester asserting: nothing may be granted.
    repeat (2) @(posedge clk); #3;
    chk("rst_ctl", {bus.req_ready_o, bus.rsp_valid_o, bus.mac_valid_o, bus.mac_ready_o, bus.rsp_err_o, busy}, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ops", ops(), 0);
    chk("rst_rsp_d", bus.rsp_d_o, 0);
    for (int r = 0; r < R; r++) pend[r] = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Round robin with everybody requesting twice.
    @(posedge clk); #3;
    grant_q.delete();
    for (int r = 0; r < R; r++) begin cur[r] = rand_job(); pend[r] = 2; end
    wait_idle("idle_rr", 2000);
    chk_order("rr_order", 0, 2 * R);

    // Single directed job on requester 1.
    j = '0;
    j.a[0][0] = 16'd1; j.a[0][1] = 16'd2; j.a[1][0] = 16'd3; j.a[1][1] = 16'd4;
    j.b[0][0] = 16'd1; j.b[1][1] = 16'd1;
    j.bs = 4'd8;
    cur[1] = j; pend[1] = 1;
    wait_idle("idle_single", 500);
    chk("single_rdy", last_rdy, 4'b0010);
    chk("single_mv_lat", mv_cyc - acc_cyc, 1);
    chk("single_d", last_d, {32'd4, 32'd3, 32'd2, 32'd1});
    chk("single_err", last_err, 0);
    chk("single_own", last_own, 1);

    // Illegal bitsize on requester 2 (too small, then too large).
    for (int t = 0; t < 2; t++) begin
      int iss0, err0;
      iss0 = iss_cnt; err0 = err_cnt;
      grant_q.delete();
      cur[2] = rand_job(); cur[2].bs = (t == 0) ? 4'd0 : 4'd9;
      cur[3] = rand_job(); cur[0] = rand_job();
      pend[2] = 1; pend[3] = 1; pend[0] = 1;
      wait_idle("idle_illegal", 1000);
      chk("ill_mac_issues", iss_cnt - iss0, 2);
      chk("ill_err_rsps", err_cnt - err0, 1);
      chk_order("ill_order", 2, 3);
    end

    // Response backpressure on the first owner, second job waits behind it.
    grant_q.delete();
    hold = 20;
    cur[1] = rand_job(); cur[2] = rand_job();
    pend[1] = 1; pend[2] = 1;
    wait_idle("idle_bp", 1000);
    chk_order("bp_order", 1, 2);
    chk("bp_hold_used", hold, 0);
    chk("bp_next_grant_gap", acc_gap, 1);

    // MAC stall in ISSUE with signed operands.
    j = '0;
    j.a[0][0] = -16'sd3; j.a[0][1] = 16'sd7; j.a[1][0] = 16'sd2; j.a[1][1] = -16'sd8;
    j.b[0][0] = 16'sd4; j.b[0][1] = -16'sd1; j.b[1][0] = -16'sd6; j.b[1][1] = 16'sd5;
    for (int i = 0; i < M; i++) for (int n = 0; n < N; n++) j.c[i][n] = -32'sd5;
    j.bs = 4'd8;
    mv_cnt = 0; stall = 5;
    cur[3] = j; pend[3] = 1;
    wait_idle("idle_stall", 500);
    chk("stall_mv_cycles", mv_cnt, 6);
    chk("stall_d", last_d, {32'hFFFF_FFD1, 32'd51, 32'd33, 32'hFFFF_FFC5});
    chk("stall_own", last_own, 3);

    // Asynchronous reset while the MAC is computing.
    mac_lat = 10;
    cur[2] = rand_job(); pend[2] = 1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #3;
      if (bus.mac_ready_o) break;
    end
    chk("run_reached", bus.mac_ready_o, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_ctl", {bus.req_ready_o, bus.rsp_valid_o, bus.mac_valid_o, bus.mac_ready_o, bus.rsp_err_o, busy}, 0);
    chk("arst_owner", owner, 0);
    chk("arst_ops", ops(), 0);
    chk("arst_rsp_d", bus.rsp_d_o, 0);
    mst = 0; cnt = 0; acc_flag = 1'b0; iss_flag = 1'b0; res_flag = 1'b0;
    prev_mv = 1'b0; stall_snap_vld = 1'b0; hold_snap_vld = 1'b0; hold = 0; stall = 0;
    bus.mac_valid_i = 1'b0; bus.mac_ready_i = 1'b0; bus.rsp_ready_i = '0;
    for (int r = 0; r < R; r++) pend[r] = 0;
    exp_q.delete();
    cap = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Fresh jobs after reset must arbitrate from pointer 0.
    @(posedge clk); #3;
    mac_lat = 3;
    grant_q.delete();
    for (int r = 0; r < R; r++) begin cur[r] = rand_job(); pend[r] = 1; end
    wait_idle("idle_post_rst", 1000);
    chk_order("post_rst_order", 0, R);

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
